// File: rtl/uart_rx_byte.sv
// uart_rx_byte
// ------------
// 8N1 asynchronous serial receiver with a single-entry holding register
// presented on a valid/ready interface.
//
// Ports:
//   clk        board clock, rising edge
//   reset_n    asynchronous active-low reset, released synchronously
//   txd        serial line from the host TX pin (idle high, asynchronous)
//   data[7:0]  received byte, stable while valid=1
//   valid      a byte is held in data
//   ready      consumer accepts data on a cycle where valid && ready
//   frame_err  one-cycle pulse when a stop bit is sampled low
//   overrun    sticky: a complete byte was dropped because data was full
//   nrecv[31:0] count of bytes loaded into the holding register (wraps)

`timescale 1ps/1ps

module uart_rx_byte #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 921600
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        txd,
  output logic [7:0]  data,
  output logic        valid,
  input  logic        ready,
  output logic        frame_err,
  output logic        overrun,
  output logic [31:0] nrecv
);

  localparam int BIT_CYC = CLK_HZ / BAUD;
  localparam int HALF    = BIT_CYC / 2;

  localparam logic [15:0] BIT_RELOAD  = 16'(BIT_CYC - 1);
  localparam logic [15:0] HALF_RELOAD = 16'(HALF - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_t;

  state_t      state;
  logic        sync_a;
  logic        rx_s;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;

  logic tick;
  logic take;

  assign tick = (cnt == 16'd0);
  assign take = valid && ready;

  // Two-flop synchronizer for the asynchronous line. Both flops come out of
  // reset high so a reset never looks like a falling start edge by itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_a <= 1'b1;
      rx_s   <= 1'b1;
    end else begin
      sync_a <= txd;
      rx_s   <= sync_a;
    end
  end

  // Receive state machine, bit timer and output interface in one block.
  // The timer counts down while a frame is in progress; "tick" (cnt==0) marks
  // each sample point. The first reload is half a bit so that every later
  // sample lands in the middle of its bit. Returning to IDLE at mid-stop
  // leaves half a bit to catch the next start edge, so back-to-back frames
  // need no idle gap. A commit and a handshake may coincide: the commit's
  // valid<=1 is written after the handshake's valid<=0, so it wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      cnt       <= 16'd0;
      bit_idx   <= 3'd0;
      shreg     <= 8'd0;
      data      <= 8'd0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      nrecv     <= 32'd0;
    end else begin
      frame_err <= 1'b0;

      if (take) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end

      if ((state == ST_START || state == ST_DATA || state == ST_STOP) && !tick) begin
        cnt <= cnt - 16'd1;
      end

      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            cnt   <= HALF_RELOAD;
            state <= ST_START;
          end
        end

        ST_START: begin
          if (tick) begin
            if (rx_s) begin
              state <= ST_IDLE;
            end else begin
              cnt     <= BIT_RELOAD;
              bit_idx <= 3'd0;
              state   <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (tick) begin
            shreg   <= {rx_s, shreg[7:1]};
            cnt     <= BIT_RELOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
            end
          end
        end

        ST_STOP: begin
          if (tick) begin
            if (rx_s) begin
              if (!valid || ready) begin
                data  <= shreg;
                valid <= 1'b1;
                nrecv <= nrecv + 32'd1;
              end else begin
                overrun <= 1'b1;
              end
              state <= ST_IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= ST_BREAK;
            end
          end
        end

        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
